// File: rtl/i2s_rx.sv
// I2S slave receiver: deserialises one left/right sample pair per frame from an
// externally clocked sck/ws/sd bus and presents it on a valid/ready output.
module i2s_rx #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] output_l_tdata,
   output logic [WIDTH-1:0] output_r_tdata,
   output logic             output_tvalid,
   input  logic             output_tready,
   input  logic             sck,
   input  logic             ws,
   input  logic             sd
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic             sck_q, sck_d;
   logic             sck_last_q, sck_last_d;
   logic             ws_q, ws_d;
   logic             sd_q, sd_d;
   logic             last_ws_q, last_ws_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] l_hold_q, l_hold_d;
   logic             left_ok_q, left_ok_d;
   logic [WIDTH-1:0] out_l_q, out_l_d;
   logic [WIDTH-1:0] out_r_q, out_r_d;
   logic             tvalid_q, tvalid_d;

   logic             sck_edge;
   logic [WIDTH-1:0] word;

   assign sck_edge = sck_q & ~sck_last_q;
   assign word     = {shift_q[WIDTH-2:0], sd_q};

   always_comb begin
      sck_d      = sck;
      sck_last_d = sck_q;
      ws_d       = ws;
      sd_d       = sd;
      last_ws_d  = last_ws_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      l_hold_d   = l_hold_q;
      left_ok_d  = left_ok_q;
      out_l_d    = out_l_q;
      out_r_d    = out_r_q;
      tvalid_d   = tvalid_q;

      if (tvalid_q && output_tready) begin
         tvalid_d = 1'b0;
      end

      if (sck_edge) begin
         if (ws_q != last_ws_q) begin
            // Channel boundary: this bit is the previous channel's LSB slot.
            last_ws_d = ws_q;
            bit_cnt_d = CNT_FULL;
            if (bit_cnt_q != '0) begin
               left_ok_d = 1'b0;
            end
         end else if (bit_cnt_q != '0) begin
            shift_d   = word;
            bit_cnt_d = bit_cnt_q - CNT_ONE;
            if (bit_cnt_q == CNT_ONE) begin
               if (!last_ws_q) begin
                  l_hold_d  = word;
                  left_ok_d = 1'b1;
               end else if (left_ok_q) begin
                  // A load wins over a same-cycle transfer and over backpressure.
                  out_l_d   = l_hold_q;
                  out_r_d   = word;
                  tvalid_d  = 1'b1;
                  left_ok_d = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q      <= 1'b0;
         sck_last_q <= 1'b0;
         ws_q       <= 1'b0;
         sd_q       <= 1'b0;
         last_ws_q  <= 1'b0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         l_hold_q   <= '0;
         left_ok_q  <= 1'b0;
         out_l_q    <= '0;
         out_r_q    <= '0;
         tvalid_q   <= 1'b0;
      end else begin
         sck_q      <= sck_d;
         sck_last_q <= sck_last_d;
         ws_q       <= ws_d;
         sd_q       <= sd_d;
         last_ws_q  <= last_ws_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         l_hold_q   <= l_hold_d;
         left_ok_q  <= left_ok_d;
         out_l_q    <= out_l_d;
         out_r_q    <= out_r_d;
         tvalid_q   <= tvalid_d;
      end
   end

   assign output_l_tdata = out_l_q;
   assign output_r_tdata = out_r_q;
   assign output_tvalid  = tvalid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: table of frames, hand-built corner sequences and a
// randomised run checked against a segment-level model of the framing rules.
module tb_i2s_rx;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             sck, ws, sd;
   logic             tready;
   logic [WIDTH-1:0] l_data, r_data;
   logic             tvalid;

   logic rdy_fixed, rdy_rand_en, rdy_rand;
   assign tready = rdy_rand_en ? rdy_rand : rdy_fixed;

   always #5 clk = ~clk;

   i2s_rx #(.WIDTH(WIDTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .output_l_tdata (l_data),
      .output_r_tdata (r_data),
      .output_tvalid  (tvalid),
      .output_tready  (tready),
      .sck            (sck),
      .ws             (ws),
      .sd             (sd)
   );

   typedef struct {
      int          l_len;
      int          r_len;
      logic [31:0] l_bits;   // left-aligned: first bit sent is bit 31
      logic [31:0] r_bits;
      bit          exp_beat;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   vec_t        vecs[6];
   int          checks = 0;
   int          errors = 0;
   int          vcyc;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   bit          mdl_ws[$];
   bit          mdl_sd[$];

   always @(posedge clk) rdy_rand <= ($urandom_range(3) != 0);

   always @(negedge clk) begin
      if (!rst && tvalid) vcyc++;
      if (!rst && tvalid && tready) got_q.push_back({l_data, r_data});
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One sck period: data changes while sck is low, sampled on the rising half.
   task automatic send_bit(input bit w, input bit d);
      sck = 1'b0; ws = w; sd = d;
      mdl_ws.push_back(w);
      mdl_sd.push_back(d);
      tick(4);
      sck = 1'b1;
      tick(4);
   endtask

   task automatic send_slot(input bit w, input logic [31:0] bits, input int len);
      send_bit(w, 1'($urandom_range(1)));
      for (int i = 0; i < len; i++) send_bit(w, bits[31-i]);
   endtask

   task automatic send_frame(input logic [31:0] lb, input int ll, input logic [31:0] rb, input int rl);
      send_slot(1'b0, lb, ll);
      send_slot(1'b1, rb, rl);
   endtask

   task automatic do_reset(input bit w);
      rst = 1'b1; sck = 1'b0; ws = w; sd = 1'b0;
      tick(3);
      rst = 1'b0;
      mdl_ws.delete();
      mdl_sd.delete();
      got_q.delete();
      tick(1);
   endtask

   // Model: split the post-reset bit stream into constant-ws segments. The first
   // segment never yields a usable word; in later ones the first bit is the
   // delay slot and the next WIDTH bits (if present) form the word.
   task automatic run_model();
      int          n, s, e, dlen;
      bit          first, left_ok, done;
      logic [15:0] lhold, w;
      exp_q.delete();
      n = mdl_ws.size();
      s = 0; first = 1'b1; left_ok = 1'b0; lhold = '0;
      while (s < n) begin
         e = s;
         while (e < n && mdl_ws[e] == mdl_ws[s]) e++;
         if (!first) begin
            dlen = e - s - 1;
            done = (dlen >= WIDTH);
            w = '0;
            if (done) for (int k = 0; k < WIDTH; k++) w = {w[WIDTH-2:0], mdl_sd[s+1+k]};
            if (mdl_ws[s] == 1'b0) begin
               left_ok = done;
               lhold   = w;
            end else begin
               if (done && left_ok) exp_q.push_back({lhold, w});
               left_ok = 1'b0;
            end
         end
         first = 1'b0;
         s = e;
      end
   endtask

   initial begin
      vecs[0] = '{16, 16, 32'hA5A5_0000, 32'h1234_0000, 1'b1, 16'hA5A5, 16'h1234};
      vecs[1] = '{32, 32, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 16'hDEAD, 16'h0123};
      vecs[2] = '{10, 16, 32'h5555_0000, 32'hBEEF_0000, 1'b0, 16'h0000, 16'h0000};
      vecs[3] = '{16, 16, 32'h0F0F_0000, 32'hF0F0_0000, 1'b1, 16'h0F0F, 16'hF0F0};
      vecs[4] = '{16, 15, 32'h1111_0000, 32'h2222_0000, 1'b0, 16'h0000, 16'h0000};
      vecs[5] = '{17, 20, 32'h1357_8000, 32'h9ABC_F000, 1'b1, 16'h1357, 16'h9ABC};

      rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
      rdy_fixed = 1'b1; rdy_rand_en = 1'b0; vcyc = 0;
      tick(3);
      chk("rst_l", 64'(l_data), 64'h0);
      chk("rst_r", 64'(r_data), 64'h0);
      chk("rst_valid", 64'(tvalid), 64'h0);
      rst = 1'b0;
      tick(2);

      // Short ws=1 lead-in gives the first left slot a real channel boundary.
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);

      foreach (vecs[i]) begin
         got_q.delete();
         vcyc = 0;
         send_frame(vecs[i].l_bits, vecs[i].l_len, vecs[i].r_bits, vecs[i].r_len);
         tick(20);
         chk($sformatf("vec%0d_beats", i), 64'(got_q.size()), vecs[i].exp_beat ? 64'd1 : 64'd0);
         chk($sformatf("vec%0d_vcyc", i), 64'(vcyc), vecs[i].exp_beat ? 64'd1 : 64'd0);
         if (vecs[i].exp_beat && got_q.size() > 0)
            chk($sformatf("vec%0d_data", i), 64'(got_q[0]), 64'({vecs[i].exp_l, vecs[i].exp_r}));
      end

      // Backpressure: the second pair overwrites the first; one beat after release.
      rdy_fixed = 1'b0;
      got_q.delete();
      send_frame(32'h1111_0000, 16, 32'h2222_0000, 16);
      tick(10);
      chk("bp_valid1", 64'(tvalid), 64'h1);
      chk("bp_data1", 64'({l_data, r_data}), 64'h1111_2222);
      send_frame(32'h3333_0000, 16, 32'h4444_0000, 16);
      tick(10);
      chk("bp_data2", 64'({l_data, r_data}), 64'h3333_4444);
      tick(40);
      chk("bp_hold_valid", 64'(tvalid), 64'h1);
      chk("bp_hold_data", 64'({l_data, r_data}), 64'h3333_4444);
      rdy_fixed = 1'b1;
      tick(3);
      chk("bp_beats", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) chk("bp_beat_data", 64'(got_q[0]), 64'h3333_4444);
      chk("bp_valid_clr", 64'(tvalid), 64'h0);

      // Reset in the middle of a right slot while a pair is still pending.
      rdy_fixed = 1'b0;
      send_frame(32'h7777_0000, 16, 32'h8888_0000, 16);
      tick(5);
      chk("mr_pending", 64'(tvalid), 64'h1);
      send_slot(1'b0, 32'h5A5A_0000, 16);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'($urandom_range(1)));
      sck = 1'b0; ws = 1'b1; sd = 1'b1;
      tick(2);
      #3 rst = 1'b1;
      #1;
      chk("mr_rst_valid", 64'(tvalid), 64'h0);
      chk("mr_rst_data", 64'({l_data, r_data}), 64'h0);
      tick(3);
      rst = 1'b0;
      rdy_fixed = 1'b1;
      got_q.delete();
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'($urandom_range(1)));
      send_frame(32'hCAFE_0000, 16, 32'hBABE_0000, 16);
      tick(20);
      chk("mr_beats", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) chk("mr_data", 64'(got_q[0]), 64'hCAFE_BABE);

      // Start-up with ws=1 partway through a long right slot.
      do_reset(1'b1);
      for (int i = 0; i < 20; i++) send_bit(1'b1, 1'($urandom_range(1)));
      send_frame(32'h2468_0000, 16, 32'h1357_0000, 16);
      send_frame(32'h1122_0000, 16, 32'h3344_0000, 16);
      tick(20);
      chk("su_beats", 64'(got_q.size()), 64'd2);
      if (got_q.size() > 0) chk("su_first", 64'(got_q[0]), 64'h2468_1357);

      // Randomised frames, slot lengths around WIDTH, random ready.
      rdy_rand_en = 1'b1;
      for (int it = 0; it < 3; it++) begin
         bit lead_ws;
         int lead_n;
         lead_ws = 1'($urandom_range(1));
         lead_n  = $urandom_range(1, 20);
         do_reset(lead_ws);
         for (int i = 0; i < lead_n; i++) send_bit(lead_ws, 1'($urandom_range(1)));
         for (int f = 0; f < 6; f++)
            send_frame($urandom, $urandom_range(WIDTH-2, WIDTH+6),
                       $urandom, $urandom_range(WIDTH-2, WIDTH+6));
         tick(40);
         run_model();
         chk($sformatf("rnd%0d_beats", it), 64'(got_q.size()), 64'(exp_q.size()));
         for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk($sformatf("rnd%0d_beat%0d", it, k), 64'(got_q[k]), 64'(exp_q[k]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
